// File: rtl/logs_pkg.sv
// logs_pkg
// Shared definitions for the logistic-map orbit capture block: the default
// fraction width, the iterator's result spacing and the sequencer state set.
package logs_pkg;

    localparam int FRAC_DEFAULT = 4;

    // Cycles between successive iterator results for a given fraction width.
    function automatic int cycle_len(input int f);
        return 2 * f + 3;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESET_ITER = 3'd1,
        S_WARM       = 3'd2,
        S_CAPTURE    = 3'd3,
        S_PRESENT    = 3'd4,
        S_STEP       = 3'd5,
        S_DONE       = 3'd6
    } state_t;

endpackage

// File: rtl/logs_pulse_counter.sv
// logs_pulse_counter
// Loadable down-counter that counts iterator result pulses. terminal is high
// while exactly one pulse remains, so "pulse && terminal" marks the final
// pulse of the loaded run.
// Ports:
//   clk        clock
//   rst_n      synchronous reset, active-low
//   load       load load_value (has priority over pulse)
//   load_value number of pulses to count
//   pulse      one result pulse; decrements while non-zero
//   terminal   one pulse remaining
module logs_pulse_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pulse,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    // Count down from the loaded value, stopping at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (pulse && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/logs_orbit_capture.sv
// logs_orbit_capture
// Sweeps r across COLS columns for a bifurcation plot. For each column it
// resets the logistic-map iterator, discards WARMUP results, bins NSAMP
// results into a one-hot-per-value bitmap and offers the column downstream
// over valid/ready before stepping r (saturating) to the next column.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a sweep (only honoured when idle)
//   x_in/x_ready iterator result and its strobe
//   r_out        r driven to the iterator (2.FRAC)
//   iter_reset   active-high reset to the iterator
//   col_bitmap   bit k set when some captured x equalled k
//   col_index    column number of col_bitmap
//   col_valid    column offered; col_ready downstream accepts
//   busy         high whenever not idle
//   done         one-cycle pulse after the last column is accepted
module logs_orbit_capture
    import logs_pkg::*;
#(
    parameter int              FRAC    = FRAC_DEFAULT,
    parameter logic [FRAC+1:0] R_START = 6'h30,
    parameter logic [FRAC+1:0] R_STEP  = 6'h01,
    parameter int              COLS    = 16,
    parameter int              WARMUP  = 8,
    parameter int              NSAMP   = 16,
    localparam int             IDX_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FRAC-1:0]        x_in,
    input  logic                   x_ready,
    output logic [FRAC+1:0]        r_out,
    output logic                   iter_reset,
    output logic [(1<<FRAC)-1:0]   col_bitmap,
    output logic [IDX_W-1:0]       col_index,
    output logic                   col_valid,
    input  logic                   col_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_MAX = (WARMUP > NSAMP) ? WARMUP : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] SAMP_LOAD = CNT_W'(NSAMP);
    localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(COLS - 1);

    state_t state;
    state_t next_state;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_pulse;
    logic             cnt_terminal;

    logic             iter_reset_d;
    logic             busy_d;
    logic             col_valid_d;
    logic             done_d;

    logic [FRAC+2:0]  r_sum;
    logic [FRAC+1:0]  r_sat;

    logs_pulse_counter #(
        .WIDTH (CNT_W)
    ) u_pulse_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .pulse      (cnt_pulse),
        .terminal   (cnt_terminal)
    );

    // One extra bit catches the carry so r saturates at all-ones instead of wrapping.
    assign r_sum = {1'b0, r_out} + {1'b0, R_STEP};
    assign r_sat = r_sum[FRAC+2] ? {(FRAC+2){1'b1}} : r_sum[FRAC+1:0];

    // State register; the status outputs are registered alongside it so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            iter_reset <= 1'b1;
            busy       <= 1'b0;
            col_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            iter_reset <= iter_reset_d;
            busy       <= busy_d;
            col_valid  <= col_valid_d;
            done       <= done_d;
        end
    end

    // Next-state logic. The counter's terminal flag marks the last pulse of
    // the warm-up or capture run, so that pulse itself triggers the move.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start) next_state = S_RESET_ITER;
            S_RESET_ITER: next_state = (WARMUP == 0) ? S_CAPTURE : S_WARM;
            S_WARM:       if (x_ready && cnt_terminal) next_state = S_CAPTURE;
            S_CAPTURE:    if (x_ready && cnt_terminal) next_state = S_PRESENT;
            S_PRESENT: begin
                if (col_valid && col_ready) begin
                    next_state = (col_index == LAST_COL) ? S_DONE : S_STEP;
                end
            end
            S_STEP:       next_state = S_RESET_ITER;
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, registered above.
    always_comb begin
        iter_reset_d = (next_state == S_IDLE) || (next_state == S_RESET_ITER) ||
                       (next_state == S_DONE);
        busy_d       = (next_state != S_IDLE);
        col_valid_d  = (next_state == S_PRESENT);
        done_d       = (next_state == S_DONE);
    end

    // Counter control: armed while the iterator is held in reset, then
    // reloaded with the sample count on the final warm-up pulse.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = SAMP_LOAD;
        cnt_pulse      = 1'b0;
        case (state)
            S_RESET_ITER: begin
                cnt_load       = 1'b1;
                cnt_load_value = (WARMUP == 0) ? SAMP_LOAD : WARM_LOAD;
            end
            S_WARM: begin
                cnt_pulse = x_ready;
                if (x_ready && cnt_terminal) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = SAMP_LOAD;
                end
            end
            S_CAPTURE: cnt_pulse = x_ready;
            default: ;
        endcase
    end

    // Column datapath: r, column number and the bin bitmap. All three hold
    // still while the column is being presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out      <= R_START;
            col_index  <= '0;
            col_bitmap <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_out     <= R_START;
                        col_index <= '0;
                    end
                end
                S_RESET_ITER: col_bitmap <= '0;
                S_CAPTURE: begin
                    if (x_ready) col_bitmap[x_in] <= 1'b1;
                end
                S_STEP: begin
                    r_out     <= r_sat;
                    col_index <= col_index + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logs_orbit_capture.sv
// tb_logs_orbit_capture
// Scoreboard bench. The stimulus side plays the iterator (random or
// iterator-paced results while iter_reset is low, stray strobes while it is
// high) and the downstream sink, and pushes expected columns and done pulses
// into queues. A separate monitor pops and compares whenever the DUT
// presents a column or a done pulse.
module tb_logs_orbit_capture;
    import logs_pkg::*;

    localparam int              FRAC    = 4;
    localparam logic [FRAC+1:0] R_START = 6'h3A;
    localparam logic [FRAC+1:0] R_STEP  = 6'h03;
    localparam int              COLS    = 4;
    localparam int              WARMUP  = 2;
    localparam int              NSAMP   = 4;
    localparam int              IDX_W   = $clog2(COLS);
    localparam int              R_MAX   = (1 << (FRAC + 2)) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [FRAC-1:0]       x_in = '0;
    logic                  x_ready = 1'b0;
    logic [FRAC+1:0]       r_out;
    logic                  iter_reset;
    logic [(1<<FRAC)-1:0]  col_bitmap;
    logic [IDX_W-1:0]      col_index;
    logic                  col_valid;
    logic                  col_ready = 1'b0;
    logic                  busy;
    logic                  done;

    logs_orbit_capture #(
        .FRAC    (FRAC),
        .R_START (R_START),
        .R_STEP  (R_STEP),
        .COLS    (COLS),
        .WARMUP  (WARMUP),
        .NSAMP   (NSAMP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_in       (x_in),
        .x_ready    (x_ready),
        .r_out      (r_out),
        .iter_reset (iter_reset),
        .col_bitmap (col_bitmap),
        .col_index  (col_index),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] bitmap;
        int          index;
        int          r;
        int          rise_cyc;
    } col_exp_t;

    col_exp_t col_q[$];
    int       done_q[$];

    int tests = 0;
    int fails = 0;

    // Stimulus-side model state.
    int          col = 0;
    int          pulses = 0;
    int          gap = 0;
    int          hold = 0;
    int          long_hold_col = -1;
    bit          paced = 1'b0;
    bit          sweeping = 1'b0;
    logic        prev_ir = 1'b1;
    logic [15:0] cap = '0;
    int          x_dir[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected r for a column: start plus steps, clipped at the largest code.
    function automatic int exp_r(input int c);
        int v;
        v = int'(R_START) + c * int'(R_STEP);
        return (v > R_MAX) ? R_MAX : v;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_col_valid"}, col_valid, 0);
        checkOutput({tag, "_iter_reset"}, iter_reset, 1);
        checkOutput({tag, "_bitmap"}, col_bitmap, 0);
        checkOutput({tag, "_col_index"}, col_index, 0);
        checkOutput({tag, "_r_out"}, r_out, R_START);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // One cycle of iterator + sink behaviour, called just after a falling edge.
    task automatic applyStimulus();
        int  xv;
        bit  fire;
        x_ready = 1'b0;
        start   = 1'b0;
        if (iter_reset) begin
            pulses = 0;
            gap    = 0;
            cap    = '0;
            if ($urandom_range(0, 3) == 0) begin
                x_ready = 1'b1;
                x_in    = FRAC'($urandom);
            end
        end else begin
            if (prev_ir && sweeping) checkOutput("bitmap_cleared", col_bitmap, 0);
            gap++;
            fire = paced ? ((gap % cycle_len(FRAC)) == 0) : ($urandom_range(0, 2) == 0);
            if (fire) begin
                if (x_dir.size() > 0) xv = x_dir.pop_front();
                else xv = int'($urandom_range(0, (1 << FRAC) - 1));
                x_ready = 1'b1;
                x_in    = FRAC'(xv);
                if (pulses >= WARMUP && pulses < WARMUP + NSAMP) cap[xv] = 1'b1;
                if (pulses == WARMUP + NSAMP - 1) begin
                    col_exp_t e;
                    e.bitmap   = cap;
                    e.index    = col;
                    e.r        = exp_r(col);
                    e.rise_cyc = cyc + 1;
                    col_q.push_back(e);
                end
                pulses++;
            end
            if (busy && $urandom_range(0, 5) == 0) start = 1'b1;
        end
        prev_ir = iter_reset;
        if (col_valid) begin
            if (hold > 0) begin
                col_ready = 1'b0;
                hold--;
            end else begin
                col_ready = 1'b1;
                col++;
                if (col == COLS) begin
                    done_q.push_back(cyc + 1);
                    sweeping = 1'b0;
                end
                hold = (col == long_hold_col) ? 100 : int'($urandom_range(0, 3));
            end
        end else begin
            col_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Full sweep. abort_col >= 0 applies a one-cycle reset partway through
    // capture of that column instead of finishing.
    task automatic runSweep(input int hold_col, input bit directed, input bit pace, input int abort_col);
        int budget;
        @(negedge clk);
        col           = 0;
        pulses        = 0;
        gap           = 0;
        cap           = '0;
        prev_ir       = 1'b1;
        sweeping      = 1'b1;
        paced         = pace;
        long_hold_col = hold_col;
        hold          = (hold_col == 0) ? 100 : int'($urandom_range(0, 3));
        x_dir.delete();
        if (directed) x_dir = '{15, 15, 1, 3, 3, 5};
        start     = 1'b1;
        x_ready   = 1'b0;
        col_ready = 1'b0;
        budget    = 0;
        while (sweeping && budget < 5000) begin
            @(negedge clk);
            applyStimulus();
            budget++;
            if (abort_col >= 0 && col == abort_col && pulses == WARMUP + 2 && !iter_reset) begin
                @(negedge clk);
                rst_n     = 1'b0;
                x_ready   = 1'b0;
                start     = 1'b0;
                col_ready = 1'b0;
                @(posedge clk);
                #1;
                checkResetState("mid_reset");
                @(negedge clk);
                rst_n = 1'b1;
                col_q.delete();
                done_q.delete();
                sweeping = 1'b0;
                break;
            end
        end
        checkOutput("sweep_finished", sweeping, 0);
        sweeping = 1'b0;
        repeat (4) begin
            @(negedge clk);
            applyStimulus();
        end
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_iter_reset", iter_reset, 1);
    endtask

    // Monitor: compares presented columns and done pulses with the queues.
    logic     prev_valid = 1'b0;
    col_exp_t cur;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (col_valid && !prev_valid) begin
                checkOutput("col_expected", col_q.size(), 1);
                if (col_q.size() > 0) begin
                    cur = col_q.pop_front();
                    checkOutput("col_bitmap", col_bitmap, cur.bitmap);
                    checkOutput("col_index", col_index, cur.index);
                    checkOutput("col_r_out", r_out, cur.r);
                    checkOutput("col_valid_timing", cyc, cur.rise_cyc);
                end
            end else if (col_valid) begin
                checkOutput("held_bitmap", col_bitmap, cur.bitmap);
                checkOutput("held_index", col_index, cur.index);
                checkOutput("held_r_out", r_out, cur.r);
                checkOutput("held_iter_reset", iter_reset, 0);
            end
            if (done) begin
                checkOutput("done_expected", done_q.size(), 1);
                if (done_q.size() > 0) checkOutput("done_timing", cyc, done_q.pop_front());
            end
            prev_valid = col_valid;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            applyStimulus();
        end
        checkOutput("idle_after_reset_busy", busy, 0);

        runSweep(-1, 1'b1, 1'b1, -1);
        runSweep(1, 1'b0, 1'b0, -1);
        runSweep(-1, 1'b0, 1'b0, 1);
        runSweep(2, 1'b0, 1'b1, -1);
        runSweep(-1, 1'b0, 1'b0, -1);

        checkOutput("leftover_columns", col_q.size(), 0);
        checkOutput("leftover_done", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
